// File: rtl/video_frame_gate.sv
// Frame gate between a camera Avalon-ST source and a video DMA sink. After an arm pulse it
// forwards one whole frame (or every frame in continuous mode), trimming and flagging malformed frames.
module video_frame_gate #(
  parameter int DATA_W     = 24,
  parameter int MAX_PIXELS = 76800,
  parameter int CNT_W      = 17
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              arm,
  input  logic              continuous,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_sop,
  output logic              src_eop,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_short,
  output logic              err_long,
  output logic              err_sop
);

  typedef enum logic [1:0] {IDLE, WAIT_SOP, PASS, FLUSH} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PIXELS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
  logic              done_q, done_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              es_q, es_d, el_q, el_d, ep_q, ep_d;
  logic              rst_done_q;
  logic              out_free, eop_xfer, rdy, snk_acc, fwd;

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no path can infer a latch.
    out_free = !valid_q || src_ready;
    eop_xfer = valid_q && src_ready && eop_q;
    rdy      = 1'b1;
    case (state_q)
      PASS:     rdy = out_free && !(valid_q && eop_q);
      // Only stalls when a trimmed frame's eop is still waiting on the DMA after FLUSH.
      WAIT_SOP: rdy = out_free;
      default:  rdy = 1'b1;
    endcase
    snk_ready = rst_done_q && rdy;
    snk_acc   = snk_valid && snk_ready;
    fwd       = snk_acc && ((state_q == WAIT_SOP && snk_sop) || state_q == PASS);
    idx       = (state_q == PASS) ? cnt_q : '0;

    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    valid_d = valid_q && !src_ready;
    done_d  = eop_xfer;
    fcnt_d  = fcnt_q + 16'(eop_xfer);
    es_d    = es_q;
    el_d    = el_q;
    ep_d    = ep_q;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = WAIT_SOP;
          es_d    = 1'b0;
          el_d    = 1'b0;
          ep_d    = 1'b0;
        end
      end
      WAIT_SOP: if (fwd) state_d = PASS;
      PASS:     if (eop_xfer) state_d = continuous ? WAIT_SOP : IDLE;
      FLUSH:    if (snk_acc && snk_eop) state_d = continuous ? WAIT_SOP : IDLE;
      default:  state_d = IDLE;
    endcase

    if (fwd) begin
      valid_d = 1'b1;
      data_d  = snk_data;
      sop_d   = (idx == '0);
      eop_d   = snk_eop || (idx == LAST_IDX);
      cnt_d   = idx + CNT_W'(1);
      if (snk_sop && idx != '0)       ep_d = 1'b1;
      if (snk_eop && idx != LAST_IDX) es_d = 1'b1;
      if (!snk_eop && idx == LAST_IDX) begin
        el_d    = 1'b1;
        state_d = FLUSH;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      fcnt_q     <= '0;
      es_q       <= 1'b0;
      el_q       <= 1'b0;
      ep_q       <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      fcnt_q     <= fcnt_d;
      es_q       <= es_d;
      el_q       <= el_d;
      ep_q       <= ep_d;
      rst_done_q <= 1'b1;
    end
  end

  assign src_data    = data_q;
  assign src_sop     = sop_q;
  assign src_eop     = eop_q;
  assign src_valid   = valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
  assign err_short   = es_q;
  assign err_long    = el_q;
  assign err_sop     = ep_q;

endmodule
